keypad_scan_controller: RTL and testbench

KEYPAD_SCAN_CONTROLLER -- requirements
Module: keypad_scan_controller

---
 rtl/keypad_scan_controller.sv | 142 ++++++++++++++
 tb/tb_keypad_scan_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_controller.sv
`default_nettype none
// ============================================================================
// Module : keypad_scan_controller
// Brief  : 4x4 matrix keypad scanner with press and release debouncing.
// Rev    : 1.0 - initial release
// ============================================================================
module keypad_scan_controller #(
  parameter int SETTLE_CYCLES   = 48,
  parameter int DEBOUNCE_CYCLES = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_sync,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int C_MAX_CYCLES = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int C_CNT_W      = $clog2(C_MAX_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_SETTLE_LAST   = C_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_DEBOUNCE_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE       = C_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } state_t;

  state_t             r_state;
  logic [C_CNT_W-1:0] r_cnt;
  logic [1:0]         r_col;
  logic [1:0]         r_row;
  logic [3:0]         r_cols;
  logic [3:0]         r_key_code;
  logic               r_key_valid;
  logic               r_key_held;

  logic       w_row_low;
  logic       w_any_low;
  logic [1:0] w_low_row;

  assign w_row_low = ~rows_sync[r_row];
  assign w_any_low = ~&rows_sync;

  // Lowest-index closed row wins when several rows share the driven column.
  always_comb begin
    w_low_row = 2'd3;
    if (!rows_sync[2]) w_low_row = 2'd2;
    if (!rows_sync[1]) w_low_row = 2'd1;
    if (!rows_sync[0]) w_low_row = 2'd0;
  end

  function automatic logic [3:0] f_key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] v;
    case ({row, col})
      4'h0: v = 4'h1;  4'h1: v = 4'h2;  4'h2: v = 4'h3;  4'h3: v = 4'hA;
      4'h4: v = 4'h4;  4'h5: v = 4'h5;  4'h6: v = 4'h6;  4'h7: v = 4'hB;
      4'h8: v = 4'h7;  4'h9: v = 4'h8;  4'hA: v = 4'h9;  4'hB: v = 4'hC;
      4'hC: v = 4'hE;  4'hD: v = 4'h0;  4'hE: v = 4'hF;  4'hF: v = 4'hD;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_SCAN;
      r_cnt       <= '0;
      r_col       <= 2'd0;
      r_row       <= 2'd0;
      r_cols      <= 4'b1110;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (r_cnt == C_SETTLE_LAST) begin
            r_cnt <= '0;
            if (w_any_low) begin
              r_row   <= w_low_row;
              r_state <= ST_PRESS_DB;
            end else begin
              // Rotating the column word keeps exactly one low bit at all times.
              r_col  <= r_col + 2'd1;
              r_cols <= {r_cols[2:0], r_cols[3]};
            end
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
        ST_PRESS_DB: begin
          if (!w_row_low) begin
            r_cnt   <= '0;
            r_col   <= r_col + 2'd1;
            r_cols  <= {r_cols[2:0], r_cols[3]};
            r_state <= ST_SCAN;
          end else if (r_cnt == C_DEBOUNCE_LAST) begin
            r_cnt       <= '0;
            r_key_code  <= f_key_map(r_row, r_col);
            r_key_valid <= 1'b1;
            r_key_held  <= 1'b1;
            r_state     <= ST_HELD;
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
        ST_HELD: begin
          if (!w_row_low) begin
            r_cnt   <= '0;
            r_state <= ST_RELEASE_DB;
          end
        end
        ST_RELEASE_DB: begin
          if (w_row_low) begin
            r_state <= ST_HELD;
          end else if (r_cnt == C_DEBOUNCE_LAST) begin
            r_cnt      <= '0;
            r_key_held <= 1'b0;
            r_col      <= r_col + 2'd1;
            r_cols     <= {r_cols[2:0], r_cols[3]};
            r_state    <= ST_SCAN;
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  assign cols      = r_cols;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_keypad_scan_controller
// Brief  : Directed and randomized keypad bench against a run-length key model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_controller;

  localparam int S = 4;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows_sync;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  always #5 clk = ~clk;

  keypad_scan_controller #(.SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows_sync (rows_sync),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  // Physical keypad: bit r*4+c closed. bounce forces all rows open for a cycle.
  logic [15:0] keys   = 16'h0;
  logic        bounce = 1'b0;

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  // Model: phase 0 scanning, 1 confirming press, 2 held, 3 confirming release.
  int         m_phase, m_col, m_row, m_run;
  logic [3:0] m_code;
  logic       m_valid, m_held;

  function automatic logic [3:0] rows_from(input logic [15:0] k, input logic [3:0] cv);
    logic [3:0] rw = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (k[r*4+c] && !cv[c]) rw[r] = 1'b0;
    return rw;
  endfunction

  function automatic int lowest_low(input logic [3:0] rw);
    for (int i = 0; i < 4; i++) if (!rw[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_col = 0; m_row = 0; m_run = 0;
    m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] rw);
    m_valid = 1'b0;
    case (m_phase)
      0: begin
        m_run++;
        if (m_run == S) begin
          m_run = 0;
          if (rw == 4'hF) m_col = (m_col + 1) % 4;
          else begin m_row = lowest_low(rw); m_phase = 1; end
        end
      end
      1: begin
        if (rw[m_row]) begin m_phase = 0; m_run = 0; m_col = (m_col + 1) % 4; end
        else begin
          m_run++;
          if (m_run == D) begin
            m_code = keymap[m_row*4+m_col]; m_valid = 1'b1; m_held = 1'b1;
            m_phase = 2; m_run = 0;
          end
        end
      end
      2: if (rw[m_row]) begin m_phase = 3; m_run = 0; end
      default: begin
        if (!rw[m_row]) m_phase = 2;
        else begin
          m_run++;
          if (m_run == D) begin m_held = 1'b0; m_col = (m_col + 1) % 4; m_phase = 0; m_run = 0; end
        end
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [3:0] exp_cols = 4'hF;
    exp_cols[m_col] = 1'b0;
    check("cols", cols, exp_cols);
    check("key_code", key_code, m_code);
    check("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
    check("key_held", {3'b0, key_held}, {3'b0, m_held});
  endtask

  task automatic cycle();
    rows_sync = bounce ? 4'hF : rows_from(keys, cols);
    @(posedge clk);
    if (reset) model_reset(); else model_step(rows_sync);
    #1;
    compare_all();
    if (key_valid) pulses++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int limit);
    int g = 0;
    while (!key_valid && g < limit) begin cycle(); g++; end
    check("wait_key_valid", {3'b0, key_valid}, 4'h1);
  endtask

  task automatic wait_phase(input int ph, input int limit);
    int g = 0;
    while (m_phase != ph && g < limit) begin cycle(); g++; end
    check("wait_press_phase", 4'(m_phase), 4'(ph));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    rows_sync = 4'hF;
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;

    // Idle scanning
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (i == 3)  check("idle_cols_after4", cols, 4'hD);
      if (i == 15) check("idle_cols_wrap", cols, 4'hE);
    end
    check("idle_pulses", 4'(pulses), 4'd0);

    // Clean press r1/c2
    pulses = 0;
    keys = 16'h0040;
    repeat (40) cycle();
    check("clean_pulses", 4'(pulses), 4'd1);
    check("clean_code", key_code, 4'h6);
    check("clean_held", {3'b0, key_held}, 4'h1);
    keys = 16'h0;
    repeat (8) cycle();
    check("clean_held_during_rel", {3'b0, key_held}, 4'h1);
    cycle();
    check("clean_held_cleared", {3'b0, key_held}, 4'h0);
    check("clean_resume_cols", cols, 4'h7);

    // Bouncy press r3/c1
    pulses = 0;
    keys = 16'h2000;
    wait_phase(1, 40);
    cycle();
    cycle();
    bounce = 1'b1;
    cycle();
    bounce = 1'b0;
    check("bouncy_no_early_pulse", 4'(pulses), 4'd0);
    repeat (40) cycle();
    check("bouncy_pulses", 4'(pulses), 4'd1);
    check("bouncy_code", key_code, 4'h0);
    keys = 16'h0;
    repeat (12) cycle();

    // Release bounce r0/c3
    pulses = 0;
    keys = 16'h0008;
    wait_valid(60);
    check("relb_code", key_code, 4'hA);
    keys = 16'h0;    repeat (5) cycle();
    keys = 16'h0008; repeat (2) cycle();
    keys = 16'h0;    repeat (8) cycle();
    check("relb_held_still", {3'b0, key_held}, 4'h1);
    cycle();
    check("relb_held_cleared", {3'b0, key_held}, 4'h0);
    check("relb_pulses", 4'(pulses), 4'd1);

    // Two rows in column 0, then a rollover attempt in column 1
    pulses = 0;
    keys = 16'h1100;
    wait_valid(60);
    check("multi_code", key_code, 4'h7);
    keys = 16'h1102;
    repeat (30) cycle();
    check("rollover_pulses", 4'(pulses), 4'd1);
    check("rollover_code", key_code, 4'h7);
    check("rollover_held", {3'b0, key_held}, 4'h1);
    keys = 16'h0;
    repeat (12) cycle();
    check("rollover_released", {3'b0, key_held}, 4'h0);

    // Reset in the middle of press debounce
    do_reset();
    check("pre_code_zero", key_code, 4'h0);
    pulses = 0;
    keys = 16'h0001;
    wait_phase(1, 40);
    repeat (5) cycle();
    keys = 16'h0;
    do_reset();
    check("rst_cols", cols, 4'hE);
    repeat (20) cycle();
    check("rst_pulses", 4'(pulses), 4'd0);
    check("rst_code", key_code, 4'h0);

    // Randomized traffic
    for (int s = 0; s < 250; s++) begin
      int n, dur;
      if ($urandom_range(0, 29) == 0) do_reset();
      keys = 16'h0;
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) keys[$urandom_range(0, 15)] = 1'b1;
      dur = $urandom_range(1, 40);
      for (int j = 0; j < dur; j++) begin
        bounce = ($urandom_range(0, 7) == 0);
        cycle();
      end
      bounce = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
